mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between two requesters:
  - IF fetch port.
  - MW load/store port.
- Sits between the pipeline (pc register / Dmem access stage) and the memory macro.
- Serialises transactions with one outstanding request at a time.
- Gives data priority, with a starvation guard for fetch.
- Drops fetch responses invalidated by a branch/jump flush.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req pending before fetch is forced to win (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  AW  fetch address
- if_flush  in  1  pipeline flush; kills in-flight fetch response
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DW  fetch instruction
- d_req  in  1  data request; held stable until d_gnt
- d_we  in  1  store when 1, load when 0
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_func3  in  3  access size/sign (RV32 load/store func3)
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid / store complete
- d_rdata  out  DW  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_func3  out  3  memory access func3
- mem_gnt  in  1  memory accepted mem_req
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  DW  memory read data
- busy  out  1  state != IDLE
- owner  out  1  0 = fetch, 1 = data; valid while busy

Behaviour:
- Reset rst, synchronous, active-high.
- On reset:
  - state = IDLE.
  - mem_req, mem_we, busy, owner, drop flag, streak counter = 0.
  - mem_addr, mem_wdata, mem_func3 = 0.
- FSM states: IDLE, REQ, WAIT. owner is a registered bit.
- IDLE:
  - Arbitrate if any request is present.
  - Winner = data if d_req, except fetch wins when if_req && streak == STARVE_LIMIT.
  - Winner = fetch if only if_req.
  - if_gnt / d_gnt are combinational, asserted only in IDLE for the winner.
  - Next cycle: latch fields into mem_* regs, set mem_req = 1, set owner, go to REQ.
  - Fetch access: mem_we = 0, mem_func3 = 3'b010.
- REQ:
  - Hold mem_* stable until mem_gnt.
  - On mem_gnt: mem_req = 0, go to WAIT.
  - If mem_gnt && mem_rvalid in the same cycle: complete immediately and go to IDLE.
- WAIT:
  - On mem_rvalid: go to IDLE.
  - Response routed combinationally:
    - if_rvalid = mem_rvalid && owner == 0 && !drop && !if_flush.
    - d_rvalid = mem_rvalid && owner == 1.
  - x_rdata = mem_rdata (don't care when not valid).
- Minimum latency: gnt at cycle N, mem_req at N+1, earliest response at N+1 (same-cycle gnt+rvalid). Back-to-back throughput is one transaction per 2 cycles minimum.
- Streak counter (4 bit, saturating at STARVE_LIMIT):
  - +1 on d_gnt while if_req = 1.
  - Cleared on if_gnt, or on d_gnt while if_req = 0.
- Flush:
  - if_flush in REQ/WAIT with owner = 0 sets drop.
  - The memory transaction still completes and the response is discarded.
  - drop clears on return to IDLE.
  - if_flush in IDLE has no effect (requester withdraws if_req itself).
  - A data transaction is never affected by if_flush.
- Simultaneous d_req and if_req below the limit: data wins and fetch waits; if_req stays asserted.
- Responses arriving in IDLE (e.g. after reset mid-transaction) are ignored; no rvalid is forwarded.
- Writes return a d_rvalid completion pulse; d_rdata is a don't care for writes.
- No address alignment checking; mem_addr is passed through unmodified.

Decomposition:
- Package riscv_mem_pkg holds:
  - State encoding (IDLE/REQ/WAIT).
  - Owner encoding (OWN_IF = 0, OWN_D = 1).
  - FUNC3_LW = 3'b010.
  - Default STARVE_LIMIT.
- One sub-module, mem_arb_pick: combinational priority pick plus the registered streak counter. Outputs the winner and the gnt strobes.

Test Plan:
- Fetch only: if_req, if_addr = 0x100 → if_gnt in cycle 0; mem_req/mem_addr = 0x100, func3 = 010 in cycle 1; memory gnt at 1, rvalid at 3 with 0x00500093 → if_rvalid = 1, if_rdata = 0x00500093 at cycle 3; busy low at cycle 4.
- Contention: d_req (lw 0x200) and if_req same cycle → d_gnt first, if_gnt only after d_rvalid; mem_addr sequence 0x200 then fetch address.
- Starvation: d_req held high with 6 back-to-back stores while if_req is high, STARVE_LIMIT = 4 → 4 data grants, then if_gnt, then data resumes with the streak counter reset.
- Flush: fetch in WAIT, pulse if_flush one cycle before mem_rvalid → no if_rvalid; busy returns to 0; the next d_req is granted normally.
- Reset mid-op: rst asserted in WAIT, mem_rvalid arrives one cycle after rst release → no if_rvalid/d_rvalid; all outputs at reset values.
- Same-cycle gnt+rvalid: memory asserts mem_gnt and mem_rvalid together on a store → d_rvalid in that cycle, state IDLE next cycle.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared encodings for the unified memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam logic [2:0] FUNC3_LW = 3'b010;

    localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module      : mem_arb_pick
// Description : Data-first priority pick with a fetch starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
    import riscv_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt,
    output logic pick_d
);

    localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

    logic [3:0] r_streak;
    logic       w_force_if;

    // Fetch only overrides data once it has watched c_limit data grants go by.
    assign w_force_if = if_req && (r_streak == c_limit);
    assign pick_d     = d_req && !w_force_if;
    assign d_gnt      = arb_en && pick_d;
    assign if_gnt     = arb_en && if_req && !pick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= 4'd0;
        end else if (if_gnt) begin
            r_streak <= 4'd0;
        end else if (d_gnt) begin
            if (!if_req) begin
                r_streak <= 4'd0;
            end else if (r_streak != c_limit) begin
                r_streak <= r_streak + 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Serialises fetch and load/store traffic onto one memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [2:0]    d_func3,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_func3,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    arb_state_t    r_state;
    logic          r_owner;
    logic          r_drop;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [2:0]    r_mem_func3;

    logic w_arb_en;
    logic w_if_gnt;
    logic w_d_gnt;
    logic w_pick_d;
    logic w_resp;

    assign w_arb_en = (r_state == ST_IDLE);

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk    (clk),
        .rst    (rst),
        .arb_en (w_arb_en),
        .if_req (if_req),
        .d_req  (d_req),
        .if_gnt (w_if_gnt),
        .d_gnt  (w_d_gnt),
        .pick_d (w_pick_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_drop      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_func3 <= 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_d_gnt) begin
                        r_state     <= ST_REQ;
                        r_mem_req   <= 1'b1;
                        r_owner     <= OWN_D;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_func3 <= d_func3;
                    end else if (w_if_gnt) begin
                        r_state     <= ST_REQ;
                        r_mem_req   <= 1'b1;
                        r_owner     <= OWN_IF;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_mem_func3 <= FUNC3_LW;
                    end
                end
                ST_REQ: begin
                    if (r_owner == OWN_IF && if_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        if (mem_rvalid) begin
                            r_state <= ST_IDLE;
                            r_drop  <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_owner == OWN_IF && if_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        r_state <= ST_IDLE;
                        r_drop  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Responses are only honoured for an accepted request; stray ones in IDLE vanish.
    assign w_resp = mem_rvalid &&
                    ((r_state == ST_WAIT) || (r_state == ST_REQ && mem_gnt));

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign if_rvalid = w_resp && (r_owner == OWN_IF) && !r_drop && !if_flush;
    assign d_rvalid  = w_resp && (r_owner == OWN_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_func3 = r_mem_func3;
    assign busy      = (r_state != ST_IDLE);
    assign owner     = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for the unified memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_func3;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_func3;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;

    mem_port_arbiter #(
        .AW           (32),
        .DW           (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_func3    (d_func3),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_func3  (mem_func3),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .owner      (owner)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        is_d;
        logic        chk;
        logic [31:0] data;
    } rsp_t;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];
    req_t mon_req;
    rsp_t mon_rsp;

    int n_tests = 0;
    int n_fail  = 0;

    bit          resp_auto = 1'b1;
    int          resp_lat  = 2;
    int          resp_cnt  = -1;
    logic [31:0] resp_addr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_val = 32'h0050_0093;
            32'h0000_0200: mem_val = 32'hCAFE_0200;
            32'h0000_010C: mem_val = 32'h00A0_0113;
            default:       mem_val = 32'hDEAD_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    // Memory model: accepts in the cycle mem_req is seen, answers resp_lat cycles later.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_auto) begin
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem_val(resp_addr);
                        resp_cnt   = -1;
                    end
                end else if (mem_req) begin
                    mem_gnt   = 1'b1;
                    resp_addr = mem_addr;
                    if (resp_lat == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem_val(resp_addr);
                    end else begin
                        resp_cnt = resp_lat;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && mem_req && mem_gnt) begin
            if (exp_req_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mem_req_unexpected: got addr 0x%08h, expected no request", mem_addr);
            end else begin
                mon_req = exp_req_q.pop_front();
                check("mem_addr", mem_addr, mon_req.addr);
                check("mem_we", {31'b0, mem_we}, {31'b0, mon_req.we});
                check("mem_func3", {29'b0, mem_func3}, {29'b0, mon_req.f3});
                if (mon_req.we) check("mem_wdata", mem_wdata, mon_req.wdata);
            end
        end
        if (if_rvalid || d_rvalid) begin
            if (exp_rsp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rvalid_unexpected: got if_rvalid=%0b d_rvalid=%0b, expected none",
                         if_rvalid, d_rvalid);
            end else begin
                mon_rsp = exp_rsp_q.pop_front();
                check("rsp_port_is_d", {31'b0, d_rvalid}, {31'b0, mon_rsp.is_d});
                check("rsp_both_valid", {31'b0, if_rvalid && d_rvalid}, 32'd0);
                if (mon_rsp.chk)
                    check("rsp_rdata", mon_rsp.is_d ? d_rdata : if_rdata, mon_rsp.data);
            end
        end
    end

    task automatic push_req(input logic [31:0] a, input logic we, input logic [2:0] f3,
                            input logic [31:0] wd);
        req_t r;
        r.addr = a; r.we = we; r.f3 = f3; r.wdata = wd;
        exp_req_q.push_back(r);
    endtask

    task automatic push_rsp(input logic is_d, input logic chk, input logic [31:0] data);
        rsp_t r;
        r.is_d = is_d; r.chk = chk; r.data = data;
        exp_rsp_q.push_back(r);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit is_d);
        bit got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = is_d ? d_gnt : if_gnt;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL gnt_timeout: got no %s grant, expected one within 200 cycles",
                     is_d ? "data" : "fetch");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a);
        if_addr = a;
        if_req  = 1'b1;
        wait_gnt(1'b0);
        if_req  = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f3);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_func3 = f3;
        d_req   = 1'b1;
        wait_gnt(1'b1);
        d_req   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_func3 = 3'b000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_owner", {31'b0, owner}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_func3", {29'b0, mem_func3}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Fetch only, cycle-exact
        resp_lat = 2;
        push_req(32'h100, 1'b0, 3'b010, 32'h0);
        push_rsp(1'b0, 1'b1, 32'h0050_0093);
        if_addr = 32'h100; if_req = 1'b1;
        @(negedge clk);
        check("fetch_c0_if_gnt", {31'b0, if_gnt}, 32'd1);
        check("fetch_c0_d_gnt", {31'b0, d_gnt}, 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check("fetch_c1_mem_req", {31'b0, mem_req}, 32'd1);
        check("fetch_c1_busy", {31'b0, busy}, 32'd1);
        check("fetch_c1_owner", {31'b0, owner}, 32'd0);
        @(negedge clk);
        check("fetch_c2_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        check("fetch_c2_mem_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        check("fetch_c3_if_rvalid", {31'b0, if_rvalid}, 32'd1);
        @(negedge clk);
        check("fetch_c4_busy", {31'b0, busy}, 32'd0);
        idle(2);

        // Contention: load first, fetch after the load completes
        push_req(32'h200, 1'b0, 3'b010, 32'h0);
        push_req(32'h10C, 1'b0, 3'b010, 32'h0);
        push_rsp(1'b1, 1'b1, 32'hCAFE_0200);
        push_rsp(1'b0, 1'b1, 32'h00A0_0113);
        fork
            do_data(1'b0, 32'h200, 32'h0, 3'b010);
            do_fetch(32'h10C);
        join
        idle(6);

        // Starvation: four stores, forced fetch, remaining stores
        for (int i = 0; i < 4; i++) begin
            push_req(32'h400 + 32'(4 * i), 1'b1, 3'b010, 32'h1000_0000 + 32'(i));
            push_rsp(1'b1, 1'b0, 32'h0);
        end
        push_req(32'h110, 1'b0, 3'b010, 32'h0);
        push_rsp(1'b0, 1'b1, 32'hDEAD_0110);
        push_req(32'h410, 1'b1, 3'b010, 32'h1000_0004);
        push_rsp(1'b1, 1'b0, 32'h0);
        push_req(32'h414, 1'b1, 3'b000, 32'h1000_0005);
        push_rsp(1'b1, 1'b0, 32'h0);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    d_we    = 1'b1;
                    d_addr  = 32'h400 + 32'(4 * i);
                    d_wdata = 32'h1000_0000 + 32'(i);
                    d_func3 = (i == 5) ? 3'b000 : 3'b010;
                    d_req   = 1'b1;
                    wait_gnt(1'b1);
                end
                d_req = 1'b0;
            end
            do_fetch(32'h110);
        join
        idle(6);

        // Flush while the fetch is in flight: response discarded
        push_req(32'h104, 1'b0, 3'b010, 32'h0);
        if_addr = 32'h104; if_req = 1'b1;
        @(negedge clk);
        check("flush_c0_if_gnt", {31'b0, if_gnt}, 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(posedge clk); #1;
        if_flush = 1'b1;
        @(posedge clk); #1;
        if_flush = 1'b0;
        @(negedge clk);
        check("flush_c3_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        @(negedge clk);
        check("flush_c4_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        push_req(32'h200, 1'b0, 3'b010, 32'h0);
        push_rsp(1'b1, 1'b1, 32'hCAFE_0200);
        do_data(1'b0, 32'h200, 32'h0, 3'b010);
        idle(5);

        // Store with same-cycle gnt and rvalid
        resp_lat = 0;
        push_req(32'h300, 1'b1, 3'b010, 32'h1234_5678);
        push_rsp(1'b1, 1'b0, 32'h0);
        d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h1234_5678; d_func3 = 3'b010; d_req = 1'b1;
        @(negedge clk);
        check("same_c0_d_gnt", {31'b0, d_gnt}, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        check("same_c1_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        @(negedge clk);
        check("same_c2_busy", {31'b0, busy}, 32'd0);
        idle(2);

        // Reset while a fetch waits; the late response must be ignored
        resp_auto = 1'b0;
        push_req(32'h108, 1'b0, 3'b010, 32'h0);
        if_addr = 32'h108; if_req = 1'b1;
        @(posedge clk); #1;
        if_req = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rstop_c2_busy", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check("rstop_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        check("rstop_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        check("rstop_busy", {31'b0, busy}, 32'd0);
        check("rstop_mem_req", {31'b0, mem_req}, 32'd0);
        check("rstop_mem_addr", mem_addr, 32'd0);
        check("rstop_mem_func3", {29'b0, mem_func3}, 32'd0);
        check("rstop_owner", {31'b0, owner}, 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        idle(3);

        check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        check("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
